// File: rtl/comp_sgpr_pkg.sv
// comp_sgpr_pkg: shared types and helpers for the N-way voting shadow GPR bank.
// The request tuple widths below are the bank's native widths; the top-level
// DATA_WIDTH/ADDR_WIDTH parameters default to them and must stay equal to them.
package comp_sgpr_pkg;

    localparam int SGPR_DATA_WIDTH = 32;
    localparam int SGPR_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        HOLD  = 2'd1,
        FATAL = 2'd2
    } vote_state_e;

    typedef struct packed {
        logic                       we;
        logic [SGPR_ADDR_WIDTH-1:0] addr;
        logic [SGPR_DATA_WIDTH-1:0] data;
    } wr_req_t;

    // Two requests agree when both are idle, or both write the same value to the same register.
    function automatic logic req_match(input wr_req_t a, input wr_req_t b);
        return (!a.we && !b.we) ||
               (a.we && b.we && (a.addr == b.addr) && (a.data == b.data));
    endfunction

endpackage

// File: rtl/comp_sgpr_vote_majority_voter.sv
// majority_voter: purely combinational vote across the redundant cores' write requests.
// A core's tuple wins when more than half of all cores (itself included) present it;
// with two cores this degenerates to full agreement.
module majority_voter
    import comp_sgpr_pkg::*;
#(
    parameter int NUM_CORES = 3
) (
    input  wr_req_t [NUM_CORES-1:0] req_i,
    output logic                    majority_o,
    output wr_req_t                 cand_o,
    output logic [NUM_CORES-1:0]    outvoted_o
);

    localparam int VW = $clog2(NUM_CORES + 1);
    localparam logic [VW-1:0] HALF = VW'(NUM_CORES / 2);

    logic [VW-1:0] votes [NUM_CORES];

    // Count, for every core, how many cores present a tuple matching its own.
    always_comb begin
        for (int i = 0; i < NUM_CORES; i++) begin
            votes[i] = '0;
            for (int j = 0; j < NUM_CORES; j++) begin
                if (req_match(req_i[i], req_i[j])) begin
                    votes[i] = votes[i] + 1'b1;
                end
            end
        end
    end

    // Pick the lowest-index core holding a strict majority; scanning downward lets it overwrite.
    always_comb begin
        majority_o = 1'b0;
        cand_o     = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (votes[i] > HALF) begin
                majority_o = 1'b1;
                cand_o     = req_i[i];
            end
        end
    end

    // A core is outvoted only when a majority exists and its tuple differs from the winner.
    always_comb begin
        outvoted_o = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            outvoted_o[k] = majority_o && !req_match(cand_o, req_i[k]);
        end
    end

endmodule

// File: rtl/comp_sgpr_vote.sv
// comp_sgpr_vote: votes the GPR write requests of NUM_CORES redundant cores, commits the
// majority result into a shadow register bank with two read ports, retries on disagreement
// and escalates to a sticky fatal state.
// Optional feature macro: COMP_SGPR_BYPASS_EN forwards the in-flight commit to the read ports.
module comp_sgpr_vote
    import comp_sgpr_pkg::*;
#(
    parameter int DATA_WIDTH = SGPR_DATA_WIDTH,
    parameter int ADDR_WIDTH = SGPR_ADDR_WIDTH,
    parameter int NUM_CORES  = 3,
    parameter int RETRY_MAX  = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_CORES-1:0]            we_i,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0] waddr_i,
    input  logic [NUM_CORES*DATA_WIDTH-1:0] wdata_i,
    input  logic [ADDR_WIDTH-1:0]           raddr_a_i,
    output logic [DATA_WIDTH-1:0]           rdata_a_o,
    input  logic [ADDR_WIDTH-1:0]           raddr_b_i,
    output logic [DATA_WIDTH-1:0]           rdata_b_o,
    output logic                            stall_o,
    output logic [NUM_CORES-1:0]            fault_o,
    output logic                            fatal_o,
    output logic [NUM_CORES*CNT_WIDTH-1:0]  fault_cnt_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int RW    = $clog2(RETRY_MAX + 1);
    localparam logic [RW-1:0] RETRY_LAST = RW'(RETRY_MAX);

`ifdef COMP_SGPR_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    wr_req_t [NUM_CORES-1:0] req;
    wr_req_t                 cand;
    logic                    majority;
    logic [NUM_CORES-1:0]    outvoted;
    logic                    commitEn;

    vote_state_e             state_q, state_d;
    logic [RW-1:0]           retry_q, retry_d;

    logic                    cmtValid_q;
    logic [ADDR_WIDTH-1:0]   cmtAddr_q;
    logic [DATA_WIDTH-1:0]   cmtData_q;
    logic [NUM_CORES-1:0]    fault_q;
    logic [CNT_WIDTH-1:0]    cnt_q [NUM_CORES];
    logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

    // Unpack the flat per-core buses into request tuples for the voter.
    always_comb begin
        for (int k = 0; k < NUM_CORES; k++) begin
            req[k]      = '0;
            req[k].we   = we_i[k];
            req[k].addr = waddr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
            req[k].data = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    majority_voter #(
        .NUM_CORES (NUM_CORES)
    ) u_voter (
        .req_i      (req),
        .majority_o (majority),
        .cand_o     (cand),
        .outvoted_o (outvoted)
    );

    // State and retry-count registers; reset always lands back in RUN.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            retry_q <= '0;
        end else begin
            state_q <= state_d;
            retry_q <= retry_d;
        end
    end

    // Next state: a disagreement opens a HOLD window that ends in FATAL once the retries run out.
    always_comb begin
        state_d = state_q;
        retry_d = retry_q;
        unique case (state_q)
            RUN: begin
                if (!majority) begin
                    state_d = HOLD;
                    retry_d = RW'(1);
                end
            end
            HOLD: begin
                if (majority) begin
                    state_d = RUN;
                    retry_d = '0;
                end else if (retry_q == RETRY_LAST) begin
                    state_d = FATAL;
                end else begin
                    retry_d = retry_q + 1'b1;
                end
            end
            FATAL: state_d = FATAL;
            default: begin
                state_d = RUN;
                retry_d = '0;
            end
        endcase
    end

    // Outputs decoded from the state: stall while holding or dead, commit only on a live majority.
    always_comb begin
        stall_o  = 1'b0;
        fatal_o  = 1'b0;
        commitEn = 1'b0;
        unique case (state_q)
            RUN:  commitEn = majority;
            HOLD: begin
                stall_o  = 1'b1;
                commitEn = majority;
            end
            FATAL: begin
                stall_o = 1'b1;
                fatal_o = 1'b1;
            end
            default: commitEn = 1'b0;
        endcase
    end

    // Commit register: idle winners and writes to x0 never become valid, so x0 is never written.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmtValid_q <= 1'b0;
            cmtAddr_q  <= '0;
            cmtData_q  <= '0;
        end else begin
            cmtValid_q <= commitEn && cand.we && (cand.addr != '0);
            cmtAddr_q  <= cand.addr;
            cmtData_q  <= cand.data;
        end
    end

    // Fault pulses last exactly one cycle after the vote that outvoted the core.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fault_q <= '0;
        end else begin
            fault_q <= commitEn ? outvoted : '0;
        end
    end

    // Per-core saturating fault counters; they freeze in FATAL because commitEn is low there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUM_CORES; k++) begin
                cnt_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NUM_CORES; k++) begin
                if (commitEn && outvoted[k] && (cnt_q[k] != '1)) begin
                    cnt_q[k] <= cnt_q[k] + 1'b1;
                end
            end
        end
    end

    // Shadow register bank, written one cycle after the vote from the commit register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (cmtValid_q) begin
            mem_q[cmtAddr_q] <= cmtData_q;
        end
    end

    // Read muxes: optional forwarding of the in-flight commit, and x0 always reads zero.
    always_comb begin
        rdata_a_o = mem_q[raddr_a_i];
        if (BYPASS && cmtValid_q && (cmtAddr_q == raddr_a_i)) begin
            rdata_a_o = cmtData_q;
        end
        if (raddr_a_i == '0) begin
            rdata_a_o = '0;
        end
        rdata_b_o = mem_q[raddr_b_i];
        if (BYPASS && cmtValid_q && (cmtAddr_q == raddr_b_i)) begin
            rdata_b_o = cmtData_q;
        end
        if (raddr_b_i == '0) begin
            rdata_b_o = '0;
        end
    end

    // Flatten the counters onto the output bus, core k in slice k.
    always_comb begin
        for (int k = 0; k < NUM_CORES; k++) begin
            fault_cnt_o[k*CNT_WIDTH +: CNT_WIDTH] = cnt_q[k];
        end
    end

    assign fault_o = fault_q;

endmodule
